// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared fetch-controller constants and state encoding
//   FC_RESET_PC : default first fetch address after reset
//   fc_state_e  : fetch FSM states
package fetch_ctrl_pkg;
    localparam logic [31:0] FC_RESET_PC = 32'h0000_3000;
    typedef enum logic [1:0] {FC_IDLE, FC_REQ, FC_HOLD, FC_DRAIN} fc_state_e;
endpackage

// File: rtl/fetch_ctrl_skid.sv
// fetch_ctrl_skid: one-entry hold register for a word that arrives while the F buffer is full
//   clk, reset : clock, asynchronous active-high reset
//   i_load     : capture i_data this cycle
//   i_data     : incoming instruction word
//   o_data     : held instruction word
module fetch_ctrl_skid (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [31:0] i_data,
    output logic [31:0] o_data
);
    logic [31:0] r_data;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_data <= '0;
        else if (i_load) r_data <= i_data;
    end
    assign o_data = r_data;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller with one-entry F buffer, skid hold and delay-slot redirect
//   clk, reset              : clock, asynchronous active-high reset
//   FC_stall_D_i            : decode stalled, F buffer not consumed
//   FC_redirect_D_i         : taken branch/jump in D (only with stall low)
//   FC_target_D_i           : redirect target
//   FC_req_F_o, FC_addr_F_o : instruction-memory read request/address
//   FC_ack_F_i, FC_rdata_F_i: instruction-memory response
//   FC_valid_F_o, FC_instr_F_o, FC_pc_F_o : F buffer towards the F/D register
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FC_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        FC_stall_D_i,
    input  logic        FC_redirect_D_i,
    input  logic [31:0] FC_target_D_i,
    output logic        FC_req_F_o,
    output logic [31:0] FC_addr_F_o,
    input  logic        FC_ack_F_i,
    input  logic [31:0] FC_rdata_F_i,
    output logic        FC_valid_F_o,
    output logic [31:0] FC_instr_F_o,
    output logic [31:0] FC_pc_F_o
);
    fc_state_e   r_state, w_state_next;
    logic [31:0] r_pc, r_target, r_instr, r_pc_buf, w_hold_data, w_pc_seq;
    logic        r_valid, r_slot_pend;
    logic        w_consume, w_free, w_redir_full, w_redir_empty, w_ack_req;
    logic        w_load_req, w_load_hold, w_hold_load;

    assign w_consume     = r_valid && !FC_stall_D_i;
    assign w_free        = !r_valid || w_consume;
    assign w_redir_full  = FC_redirect_D_i && r_valid;
    assign w_redir_empty = FC_redirect_D_i && !r_valid;
    assign w_ack_req     = (r_state == FC_REQ) && FC_ack_F_i;
    // a pending delay slot means the word after it comes from the saved target
    assign w_pc_seq      = r_slot_pend ? r_target : r_pc + 32'd4;
    // a redirect with a valid buffer kills whatever word arrives alongside it
    assign w_load_req    = w_ack_req && w_free && !w_redir_full;
    assign w_load_hold   = (r_state == FC_HOLD) && w_consume && !FC_redirect_D_i;
    assign w_hold_load   = w_ack_req && !w_free;

    fetch_ctrl_skid u_skid (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_hold_load),
        .i_data (FC_rdata_F_i),
        .o_data (w_hold_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= FC_IDLE;
        else r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FC_IDLE:  w_state_next = FC_REQ;
            FC_REQ:   w_state_next = (w_redir_full && !FC_ack_F_i) ? FC_DRAIN :
                                     (FC_ack_F_i && !w_free) ? FC_HOLD : FC_REQ;
            FC_HOLD:  w_state_next = w_consume ? FC_REQ : FC_HOLD;
            FC_DRAIN: w_state_next = FC_ack_F_i ? FC_REQ : FC_DRAIN;
            default:  w_state_next = FC_IDLE;
        endcase
    end

    always_comb begin
        FC_req_F_o = (r_state == FC_REQ) || (r_state == FC_DRAIN);
    end

    // DRAIN keeps the old address on the bus until its ack, ignoring further redirects
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_target    <= '0;
            r_slot_pend <= 1'b0;
        end else if (r_state == FC_DRAIN) begin
            if (FC_ack_F_i) r_pc <= r_target;
        end else if (w_redir_full) begin
            r_slot_pend <= 1'b0;
            if (r_state == FC_REQ && !FC_ack_F_i) r_target <= FC_target_D_i;
            else r_pc <= FC_target_D_i;
        end else if (w_redir_empty) begin
            if (w_ack_req) begin
                r_pc <= FC_target_D_i;
            end else begin
                r_target    <= FC_target_D_i;
                r_slot_pend <= 1'b1;
            end
        end else if (w_load_req || w_load_hold) begin
            r_pc        <= w_pc_seq;
            r_slot_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_instr  <= '0;
            r_pc_buf <= '0;
        end else if (w_load_req) begin
            r_valid  <= 1'b1;
            r_instr  <= FC_rdata_F_i;
            r_pc_buf <= r_pc;
        end else if (w_load_hold) begin
            r_valid  <= 1'b1;
            r_instr  <= w_hold_data;
            r_pc_buf <= r_pc;
        end else if (w_consume) begin
            r_valid  <= 1'b0;
        end
    end

    assign FC_addr_F_o  = r_pc;
    assign FC_valid_F_o = r_valid;
    assign FC_instr_F_o = r_instr;
    assign FC_pc_F_o    = r_pc_buf;
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, SHALL set the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on posedge clk.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 FC_stall_D_i  input  1  SHALL mean decode stalled; the F buffer is not consumed.
REQ-005 FC_redirect_D_i  input  1  SHALL mean a taken branch/jump in D; hazard unit guarantees it is only asserted with FC_stall_D_i=0.
REQ-006 FC_target_D_i  input  32  SHALL be the redirect target (word aligned).
REQ-007 FC_req_F_o  output  1  SHALL be the instruction-memory read request.
REQ-008 FC_addr_F_o  output  32  SHALL be the instruction-memory read address.
REQ-009 FC_ack_F_i  input  1  SHALL mean IM returns FC_rdata_F_i this cycle; ack arrives at least 1 cycle after request.
REQ-010 FC_rdata_F_i  input  32  SHALL be the returned instruction word.
REQ-011 FC_valid_F_o  output  1  SHALL mean the F buffer holds an instruction for the F/D register.
REQ-012 FC_instr_F_o  output  32  SHALL be the buffered instruction.
REQ-013 FC_pc_F_o  output  32  SHALL be the buffered instruction's address.

Function
REQ-014 Consume SHALL be defined as FC_valid_F_o && !FC_stall_D_i; buffer is "free" when empty or consumed this cycle.
REQ-015 States SHALL be IDLE, REQ, HOLD, DRAIN; pc_q SHALL hold the address of the next/in-flight word.
REQ-016 IDLE: req=0 for one cycle after reset, then -> REQ.
REQ-017 REQ: req=1, addr=pc_q; addr SHALL stay stable and req high until ack (one outstanding request maximum).
REQ-018 REQ on ack, buffer free, no redirect: load buffer {rdata, pc_q}, valid=1, pc_q+=4, stay REQ (back-to-back requests, 1 word per ack).
REQ-019 REQ on ack, buffer not free: store word in hold register, -> HOLD, req=0.
REQ-020 HOLD: on consume, move held word to buffer, pc_q+=4, -> REQ.
REQ-021 Buffer SHALL clear valid on consume when no new word loads that cycle.
REQ-022 Redirect with buffer valid (delay slot present): delay slot consumed normally; held word discarded; pc_q<=target; in-flight request with ack this cycle dropped -> REQ; in-flight without ack -> DRAIN with target saved.
REQ-023 DRAIN: req=1, old addr held until ack; data discarded; then pc_q<=saved target, -> REQ.
REQ-024 Redirect with buffer empty: save target, set slot_pend; next word fetched from pc_q (delay slot) SHALL be kept; then pc_q<=saved target instead of +4.
REQ-025 pc_q+4 SHALL wrap modulo 2^32 without error.
REQ-026 Simultaneous ack and redirect SHALL apply redirect rules (REQ-022/024) to the acked word.

Reset
REQ-027 On reset: state=IDLE, pc_q=RESET_PC, FC_req_F_o=0, FC_addr_F_o=RESET_PC, FC_valid_F_o=0, FC_instr_F_o=0, FC_pc_F_o=0, slot_pend=0, hold/target regs=0.
REQ-028 Reset mid-request SHALL abandon the outstanding request; a late ack after reset release while in IDLE SHALL be ignored.

Structure
REQ-029 State encoding and RESET_PC default SHALL live in the shared CPU constants package.
REQ-030 Implementation SHALL be a single module; the one-entry hold register MAY be a sub-module fc_skid.

Verification
REQ-031 Reset, ack every 2nd cycle, no stall -> addr 0x3000,0x3004,0x3008; pc_F_o follows, valid pulses per ack.
REQ-032 Stall held 3 cycles while ack for 0x3004 arrives -> HOLD, req=0, instr at 0x3000 held; release -> 0x3004 presented next cycle, req for 0x3008.
REQ-033 Redirect to 0x3100 with buffer valid (0x3004) and request for 0x3008 pending -> DRAIN, 0x3008 data dropped, next addr 0x3100, 0x3004 still delivered.
REQ-034 Redirect to 0x3200 with buffer empty, request 0x3010 in flight -> 0x3010 delivered as delay slot, next addr 0x3200.
REQ-035 Ack and redirect same cycle -> acked word dropped, addr = target next cycle.
REQ-036 Assert reset during outstanding request, ack 1 cycle after release -> ignored; first fetch 0x3000.
